// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared encodings and constants for the instruction memory loader
package imem_loader_pkg;

  localparam int ADDR_W_DEFAULT = 6;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_WRITE,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - host byte stream in, instruction RAM write port out
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
);

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/imem_word_packer.sv
// rtl/imem_word_packer.sv - little-endian byte-to-word assembler with running XOR checksum
// word already includes the byte being accepted this cycle so the caller can latch it on lane 3.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        lane3,
  output logic [7:0]  checksum
);

  logic [1:0]  byte_idx;
  logic [31:0] word_q;

  always_comb begin
    word = word_q;
    if (accept) begin
      word[{byte_idx, 3'b000} +: 8] = data;
    end
  end

  assign lane3 = (byte_idx == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      byte_idx <= '0;
      word_q   <= '0;
      checksum <= '0;
    end else if (accept) begin
      byte_idx <= byte_idx + 2'd1;
      word_q   <= word;
      checksum <= checksum ^ data;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte stream loader that writes RV32I words into instruction RAM
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  imem_loader_if.slave      bus,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_written
);

  localparam logic [8:0] DEPTH = 9'(1 << ADDR_W);

  state_t          state, state_next;
  logic [ADDR_W:0] len;
  logic            accept;
  logic            start_ok;
  logic [31:0]     pk_word;
  logic            pk_lane3;
  logic [7:0]      pk_checksum;
  logic [8:0]      len_byte;
  logic [8:0]      len_clamped;

  assign accept   = bus.rx_valid && bus.rx_ready;
  assign start_ok = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);

  // Zero and oversized lengths both mean a full memory, so the word index can never wrap.
  assign len_byte    = {1'b0, bus.rx_data};
  assign len_clamped = (bus.rx_data == 8'd0 || len_byte > DEPTH) ? DEPTH : len_byte;

  imem_word_packer u_packer (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (start_ok),
    .accept   (accept && state == ST_DATA),
    .data     (bus.rx_data),
    .word     (pk_word),
    .lane3    (pk_lane3),
    .checksum (pk_checksum)
  );

  always_comb begin
    state_next   = state;
    bus.rx_ready = 1'b0;
    bus.mem_we   = 1'b0;
    case (state)
      ST_IDLE: if (start) state_next = ST_LEN;
      ST_LEN: begin
        bus.rx_ready = 1'b1;
        if (bus.rx_valid) state_next = ST_DATA;
      end
      ST_DATA: begin
        bus.rx_ready = 1'b1;
        if (bus.rx_valid && pk_lane3) state_next = ST_WRITE;
      end
      ST_WRITE: begin
        bus.mem_we = 1'b1;
        state_next = (words_written + (ADDR_W+1)'(1) == len) ? ST_CSUM : ST_DATA;
      end
      ST_CSUM: begin
        bus.rx_ready = 1'b1;
        if (bus.rx_valid) state_next = (bus.rx_data == pk_checksum) ? ST_DONE : ST_ERR;
      end
      ST_DONE, ST_ERR: if (start) state_next = ST_LEN;
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy     = (state == ST_LEN) || (state == ST_DATA) || (state == ST_WRITE) || (state == ST_CSUM);
  assign cpu_hold = busy || (state == ST_ERR);
  assign done     = (state == ST_DONE);
  assign error    = (state == ST_ERR);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      len           <= '0;
      words_written <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      state <= state_next;
      if (start_ok) words_written <= '0;
      if (state == ST_LEN && accept) len <= len_clamped[ADDR_W:0];
      if (state == ST_DATA && accept && pk_lane3) begin
        bus.mem_addr  <= words_written[ADDR_W-1:0];
        bus.mem_wdata <= pk_word;
      end
      if (state == ST_WRITE) words_written <= words_written + (ADDR_W+1)'(1);
    end
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory: receives a framed byte stream from a host link (e.g. a UART receiver) and writes 32-bit RV32I instruction words into the instruction RAM write port.
- Holds the CPU (cpu_hold) while a load is in progress.
- Sits between the host byte source and the instruction memory; the fetch side keeps reading the memory by word index as before.
- Frame format: LEN byte, then 4*N payload bytes (little-endian words), then one XOR checksum byte.

Parameters:
- ADDR_W, 6, word-address width of the instruction memory (64 words); legal range 1..8.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  single-cycle request to begin receiving a frame; ignored while busy.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data valid; a byte is accepted when rx_valid && rx_ready.
- rx_ready  out  1  loader can accept a byte this cycle.
- mem_we  out  1  one-cycle write strobe to the instruction RAM.
- mem_addr  out  ADDR_W  word index being written.
- mem_wdata  out  32  instruction word being written.
- cpu_hold  out  1  high from frame start until DONE; the CPU must not fetch while high.
- busy  out  1  state is LEN, DATA, WRITE or CSUM.
- done  out  1  frame loaded and checksum matched; held until the next start or reset.
- error  out  1  checksum mismatch; held until the next start or reset.
- words_written  out  ADDR_W+1  words written in the current or last frame.

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - State goes to IDLE.
  - rx_ready, mem_we, cpu_hold, busy, done and error are 0.
  - mem_addr, mem_wdata and words_written are 0.
  - Partial word, checksum and length registers are cleared; no write strobe is issued.
  - Reset mid-frame discards all progress. RAM words already written stay written.
- IDLE: rx_ready=0. When start=1: go to LEN; set cpu_hold=1; clear done, error, words_written, checksum and byte lane.
- LEN: rx_ready=1. On an accepted byte, len = byte. A byte value of 0 means 2^ADDR_W words. A value greater than 2^ADDR_W is clamped to 2^ADDR_W. Then go to DATA.
- DATA:
  - rx_ready=1.
  - The accepted byte is stored in lane byte_idx: lane 0 is bits 7:0, lane 3 is bits 31:24.
  - checksum ^= byte; byte_idx increments.
  - On acceptance of lane 3, go to WRITE.
- WRITE:
  - rx_ready=0; mem_we=1 for exactly one cycle.
  - mem_addr=word_idx; mem_wdata=the assembled word.
  - On exit: word_idx and words_written increment.
  - If words_written+1 == len, go to CSUM; otherwise go to DATA with byte_idx=0.
- CSUM: rx_ready=1. On an accepted byte: if byte == checksum, go to DONE; otherwise go to ERR.
- DONE: done=1, cpu_hold=0, busy=0. start=1 begins a new frame (same actions as in IDLE).
- ERR: error=1, cpu_hold stays 1, busy=0. start=1 begins a new frame.
- Latency and throughput:
  - mem_we is asserted in the cycle after the 4th byte of a word is accepted.
  - Peak throughput is 4 bytes per 5 cycles.
- Boundary conditions:
  - rx_valid with rx_ready=0 leaves no side effects; the byte is not consumed.
  - A start pulse while busy is ignored; the frame continues.
  - start and rx_valid in the same IDLE cycle: start wins, and the byte is not accepted that cycle.
  - The word index never wraps within a frame, because of the len clamp.
- mem_addr and mem_wdata are registered and hold their last values outside WRITE.

Decomposition:
- Shared package/header imem_loader_pkg holds:
  - state encodings (IDLE, LEN, DATA, WRITE, CSUM, DONE, ERR);
  - BYTES_PER_WORD = 4;
  - the default ADDR_W.
- One natural sub-module, imem_word_packer:
  - lane-select byte assembler plus running XOR checksum;
  - inputs: clear and accept strobes, byte;
  - outputs: word, lane-3 flag, checksum.

Test Plan:
1. Reset, then start; send 0x01, 0x13, 0x00, 0x00, 0x00, 0x13 -> one mem_we pulse with addr 0 and wdata 0x00000013; done=1, error=0, cpu_hold=0, words_written=1.
2. len=2 with words 0x00500093 and 0x00A00113, correct XOR checksum -> mem_we at addr 0 then addr 1 with those values; each write occurs exactly 1 cycle after the 4th byte is accepted.
3. Same frame as scenario 1 with checksum byte 0x12 -> word still written; error=1, done=0, cpu_hold stays 1; a new start clears error.
4. len=0 with ADDR_W=6 -> 64 writes at addresses 0..63; words_written=64; no address wrap.
5. Drop rx_valid for 3 cycles mid-word and pulse start mid-frame -> no extra writes; byte order and word content unaffected; start ignored.
6. Assert reset_n=0 after 2 payload bytes -> next cycle all outputs are 0 and the state is IDLE; no mem_we; a following full frame loads correctly.
